ts_output_mux: RTL

Parametrised, packet-aligned output selector for the tuner transport-stream path. It picks one of NUM_CH input TS channels for the single TS output, under control of an SPI register write. Unlike the plain selector, it never cuts a packet: it drains the old channel to a packet gap, then blanks the output until the new channel presents a sync byte. It pulses RESET_ON_CHANGE_OUT so downstream packet logic can resynchronise, and reports selection state for SPI read-back.

---
 rtl/ts_output_mux.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/ts_output_mux.sv
// ts_output_mux: packet-aligned transport-stream output selector.
// Picks one of NUM_CH TS input channels for the single TS output. A select
// write never cuts a packet: the old channel is drained to a packet gap
// (or forced after DRAIN_TIMEOUT cycles), the output is then blanked until
// the new channel presents a sync byte. Each commit pulses
// RESET_ON_CHANGE_OUT for PULSE_LEN cycles.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | output follows cur, waiting for a select write
// ST_DRAIN | output still follows cur, waiting for a gap or the timeout
// ST_HUNT  | cur committed, valid/sync blanked until cur shows a sync byte

module ts_output_mux #(
  parameter int         NUM_CH        = 4,
  parameter int         DATA_W        = 8,
  parameter logic [7:0] REG_ADDR      = 8'h20,
  parameter int         DRAIN_TIMEOUT = 1024,
  parameter int         PULSE_LEN     = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [7:0]               SPI_ADDRESS,
  input  logic [7:0]               SPI_DATA,
  input  logic                     RISING_SS,
  input  logic [NUM_CH*DATA_W-1:0] DATA_IN_BUS,
  input  logic [NUM_CH-1:0]        DCLK_BUS,
  input  logic [NUM_CH-1:0]        D_VALID_BUS,
  input  logic [NUM_CH-1:0]        P_SYNC_BUS,
  output logic [DATA_W-1:0]        DATA_OUT,
  output logic                     DCLK_OUT,
  output logic                     D_VALID_OUT,
  output logic                     P_SYNC_OUT,
  output logic                     RESET_ON_CHANGE_OUT,
  output logic [3:0]               CUR_SEL,
  output logic                     SWITCH_BUSY,
  output logic                     SEL_ERR
);

  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DCW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam int PCW = $clog2(PULSE_LEN + 1);

  localparam logic [DCW-1:0] DRAIN_LAST   = DCW'(DRAIN_TIMEOUT - 1);
  localparam logic [PCW-1:0] PULSE_RELOAD = PCW'(PULSE_LEN - 1);
  localparam logic [4:0]     NUM_CH_W     = 5'(NUM_CH);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HUNT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cur_q, cur_d;
  logic [CW-1:0]      pend_q, pend_d;
  logic               sel_err_q, sel_err_d;
  logic [DCW-1:0]     drain_cnt_q, drain_cnt_d;
  logic [PCW-1:0]     pulse_cnt_q, pulse_cnt_d;
  logic               rst_chg_q, rst_chg_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               dclk_q, dclk_d;
  logic               dv_q, dv_d;
  logic               ps_q, ps_d;

  logic               wr_sel;
  logic [3:0]         req;
  logic               req_ok;
  logic               req_valid;
  logic               req_is_cur;
  logic [CW-1:0]      req_idx;

  logic [DATA_W-1:0]  sel_data;
  logic               sel_dclk;
  logic               sel_dv;
  logic               sel_ps;
  logic               sync_hit;

  logic               commit;
  logic [CW-1:0]      commit_ch;
  logic               pass_ok;

  // Upper SPI data bits carry nothing for this register.
  logic               unused_spi_hi;
  assign unused_spi_hi = ^SPI_DATA[7:4];

  assign wr_sel     = RISING_SS && (SPI_ADDRESS == REG_ADDR);
  assign req        = SPI_DATA[3:0];
  assign req_ok     = ({1'b0, req} < NUM_CH_W);
  assign req_idx    = req[CW-1:0];
  assign req_valid  = wr_sel && req_ok;
  assign req_is_cur = (req == 4'(cur_q));

  // Route the committed channel's byte, strobe, valid and sync.
  always_comb begin
    sel_data = '0;
    sel_dclk = 1'b0;
    sel_dv   = 1'b0;
    sel_ps   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur_q == CW'(k)) begin
        sel_data = DATA_IN_BUS[k*DATA_W +: DATA_W];
        sel_dclk = DCLK_BUS[k];
        sel_dv   = D_VALID_BUS[k];
        sel_ps   = P_SYNC_BUS[k];
      end
    end
  end

  assign sync_hit = sel_dclk && sel_dv && sel_ps;

  // Next-state logic for the switch FSM, pulse timer and output stage.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    sel_err_d   = sel_err_q;
    drain_cnt_d = drain_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    rst_chg_d   = rst_chg_q;
    commit      = 1'b0;
    commit_ch   = pend_q;

    if (wr_sel) begin
      if (req_ok) begin
        sel_err_d = 1'b0;
        pend_d    = req_idx;
      end else begin
        sel_err_d = 1'b1;
      end
    end

    case (state_q)
      ST_RUN: begin
        if (req_valid && !req_is_cur) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        // A write in the same cycle as a gap wins; the gap is re-examined
        // next cycle against the new pending channel.
        if (req_valid) begin
          if (req_is_cur) begin
            state_d     = ST_RUN;
            drain_cnt_d = '0;
          end
        end else if (!sel_dv || (drain_cnt_q == DRAIN_LAST)) begin
          commit      = 1'b1;
          commit_ch   = pend_q;
          state_d     = ST_HUNT;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      ST_HUNT: begin
        if (req_valid && !req_is_cur) begin
          commit    = 1'b1;
          commit_ch = req_idx;
        end else if (sync_hit) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // rst_chg_q rises the cycle after a commit and holds for PULSE_LEN
    // cycles; pulse_cnt_q counts the remaining cycles after the first.
    if (commit) begin
      cur_d       = commit_ch;
      pulse_cnt_d = PULSE_RELOAD;
      rst_chg_d   = 1'b1;
    end else if (pulse_cnt_q != '0) begin
      pulse_cnt_d = pulse_cnt_q - 1'b1;
    end else begin
      rst_chg_d = 1'b0;
    end

    // In HUNT only the sync byte that ends the hunt is passed through.
    pass_ok = (state_q != ST_HUNT) || (sync_hit && !commit);
    data_d  = sel_data;
    dclk_d  = sel_dclk;
    dv_d    = sel_dv && pass_ok;
    ps_d    = sel_ps && pass_ok;
  end

  // State, counters and the registered output stage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_RUN;
      cur_q       <= '0;
      pend_q      <= '0;
      sel_err_q   <= 1'b0;
      drain_cnt_q <= '0;
      pulse_cnt_q <= '0;
      rst_chg_q   <= 1'b0;
      data_q      <= '0;
      dclk_q      <= 1'b0;
      dv_q        <= 1'b0;
      ps_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      sel_err_q   <= sel_err_d;
      drain_cnt_q <= drain_cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      rst_chg_q   <= rst_chg_d;
      data_q      <= data_d;
      dclk_q      <= dclk_d;
      dv_q        <= dv_d;
      ps_q        <= ps_d;
    end
  end

  assign DATA_OUT            = data_q;
  assign DCLK_OUT            = dclk_q;
  assign D_VALID_OUT         = dv_q;
  assign P_SYNC_OUT          = ps_q;
  assign RESET_ON_CHANGE_OUT = rst_chg_q;
  assign CUR_SEL             = 4'(cur_q);
  assign SWITCH_BUSY         = (state_q != ST_RUN);
  assign SEL_ERR             = sel_err_q;

endmodule
